// File: rtl/dpwm_pkg.sv
// Shared definitions for the multiphase DPWM.
//   state_e  : controller FSM encoding (idle, offset init, run)
//   wrap_add : modular add used to build the inter-phase offsets
package dpwm_pkg;

   localparam int unsigned DefaultWidth = 12;
   localparam int unsigned DefaultNph   = 4;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StInit = 2'd1,
      StRun  = 2'd2
   } state_e;

   // Both operands must already be below mod, so one subtraction is enough.
   // Callers zero-extend into 32 bits, which leaves headroom for WIDTH+1 sums.
   function automatic logic [31:0] wrap_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] mod);
      logic [31:0] sum;
      sum = a + b;
      if (sum >= mod) begin
         sum = sum - mod;
      end
      return sum;
   endfunction

endpackage

// File: rtl/dpwm_phase_cell.sv
// One DPWM phase: local period counter plus registered complementary compares.
//   i_clk, i_rst_n      : clock, synchronous active-low reset
//   i_clear             : hold counter at 0 (controller idle)
//   i_load, i_load_val  : preset counter to this phase's offset
//   i_run               : advance counter and enable outputs
//   i_fs, i_duty, i_dt1, i_dt2 : latched terminal count and shadow settings
//   o_at_end            : counter sits at terminal count
//   o_c1, o_c2          : high-side / low-side drives (one cycle after the count)
module dpwm_phase_cell
   import dpwm_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_run,
   input  logic [WIDTH-1:0] i_fs,
   input  logic [WIDTH-1:0] i_duty,
   input  logic [WIDTH-1:0] i_dt1,
   input  logic [WIDTH-1:0] i_dt2,
   output logic             o_at_end,
   output logic             o_c1,
   output logic             o_c2
);

   logic [WIDTH-1:0] r_lc;
   logic             r_c1;
   logic             r_c2;
   logic [WIDTH:0]   w_c2_lo;
   logic             w_c1;
   logic             w_c2;

   // Extra bit keeps duty+dt2 from wrapping, so an oversized sum just blanks c2.
   assign w_c2_lo = {1'b0, i_duty} + {1'b0, i_dt2};
   // c1 ends below duty and c2 starts at or above duty: they can never overlap.
   assign w_c1    = (r_lc >= i_dt1) && (r_lc < i_duty);
   assign w_c2    = ({1'b0, r_lc} >= w_c2_lo) && (r_lc <= i_fs);
   assign o_at_end = (r_lc == i_fs);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_lc <= '0;
         r_c1 <= 1'b0;
         r_c2 <= 1'b0;
      end else begin
         if (i_clear) begin
            r_lc <= '0;
         end else if (i_load) begin
            r_lc <= i_load_val;
         end else if (i_run) begin
            r_lc <= (r_lc == i_fs) ? '0 : r_lc + 1'b1;
         end
         r_c1 <= i_run && w_c1;
         r_c2 <= i_run && w_c2;
      end
   end

   assign o_c1 = r_c1;
   assign o_c2 = r_c2;

endmodule

// File: rtl/dpwm_multiphase.sv
// N-phase interleaved DPWM with complementary outputs and dead-time.
//   hf_clock, reset    : PWM clock, synchronous active-low reset
//   enable             : run request (0 returns to idle)
//   duty_cycle, deadtime1, deadtime2 : shadowed, reloaded at the phase-0 wrap
//   fs, phase_step     : terminal count and phase spacing, latched on start
//   c1, c2             : per-phase high-side / low-side drives
//   period_start       : pulse in the cycle phase-0 count is 0
//   running            : controller is in the run state
module dpwm_multiphase
   import dpwm_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth,
   parameter int unsigned NPH   = DefaultNph
) (
   input  logic             hf_clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] duty_cycle,
   input  logic [WIDTH-1:0] fs,
   input  logic [WIDTH-1:0] phase_step,
   input  logic [WIDTH-1:0] deadtime1,
   input  logic [WIDTH-1:0] deadtime2,
   output logic [NPH-1:0]   c1,
   output logic [NPH-1:0]   c2,
   output logic             period_start,
   output logic             running
);

   localparam int unsigned IdxW = (NPH > 1) ? $clog2(NPH) : 1;

   state_e           r_state;
   state_e           w_state_next;
   logic [WIDTH-1:0] r_fs_s;
   logic [WIDTH-1:0] r_ph_s;
   logic [WIDTH-1:0] r_duty_s;
   logic [WIDTH-1:0] r_dt1_s;
   logic [WIDTH-1:0] r_dt2_s;
   logic [WIDTH-1:0] r_acc;
   logic [IdxW-1:0]  r_idx;
   logic             r_period_start;
   logic [WIDTH-1:0] w_sum;
   logic             w_start;
   logic             w_run;
   logic             w_wrap;
   logic [NPH-1:0]   w_load;
   logic [NPH-1:0]   w_at_end;
   logic             w_at_end_unused;

   assign w_start = (r_state == StIdle) && enable;
   assign w_run   = (r_state == StRun) && enable;
   assign w_wrap  = w_run && w_at_end[0];
   assign w_sum   = WIDTH'(wrap_add(32'(r_acc), 32'(r_ph_s), 32'(r_fs_s) + 32'd1));
   // Only phase 0 defines the period boundary; other phases' flags are spare.
   assign w_at_end_unused = ^w_at_end;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StIdle: if (enable) w_state_next = (NPH > 1) ? StInit : StRun;
         StInit: if (r_idx == IdxW'(NPH - 1)) w_state_next = StRun;
         StRun:  w_state_next = StRun;
         default: w_state_next = StIdle;
      endcase
      if (!enable) begin
         w_state_next = StIdle;
      end
   end

   always_ff @(posedge hf_clock) begin
      if (!reset) begin
         r_state        <= StIdle;
         r_fs_s         <= '0;
         r_ph_s         <= '0;
         r_duty_s       <= '0;
         r_dt1_s        <= '0;
         r_dt2_s        <= '0;
         r_acc          <= '0;
         r_idx          <= '0;
         r_period_start <= 1'b0;
      end else begin
         r_state        <= w_state_next;
         r_period_start <= w_wrap;
         if (w_start) begin
            r_fs_s   <= fs;
            r_ph_s   <= (phase_step > fs) ? fs : phase_step;
            r_duty_s <= duty_cycle;
            r_dt1_s  <= deadtime1;
            r_dt2_s  <= deadtime2;
            r_acc    <= '0;
            r_idx    <= IdxW'(1);
         end else if (w_wrap) begin
            r_duty_s <= duty_cycle;
            r_dt1_s  <= deadtime1;
            r_dt2_s  <= deadtime2;
         end
         // One offset per init cycle; phase r_idx is preset with it.
         if (r_state == StInit) begin
            r_acc <= w_sum;
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   for (genvar k = 0; k < NPH; k++) begin : g_phase
      assign w_load[k] = (k != 0) && (r_state == StInit) && (r_idx == IdxW'(k));

      dpwm_phase_cell #(
         .WIDTH (WIDTH)
      ) u_cell (
         .i_clk      (hf_clock),
         .i_rst_n    (reset),
         .i_clear    (r_state == StIdle),
         .i_load     (w_load[k]),
         .i_load_val (w_sum),
         .i_run      (w_run),
         .i_fs       (r_fs_s),
         .i_duty     (r_duty_s),
         .i_dt1      (r_dt1_s),
         .i_dt2      (r_dt2_s),
         .o_at_end   (w_at_end[k]),
         .o_c1       (c1[k]),
         .o_c2       (c2[k])
      );
   end

   assign period_start = r_period_start;
   assign running      = (r_state == StRun);

endmodule

// File: tb/tb_dpwm_multiphase.sv
// Directed bench for dpwm_multiphase: table of duty/dead-time settings checked
// per phase against a count model, plus hand sequences for start-up, shadow
// timing, reset mid-run and an uneven offset set.
module tb_dpwm_multiphase;

   localparam int unsigned WIDTH = 12;
   localparam int unsigned NPH   = 4;

   typedef struct {
      int duty;
      int dt1;
      int dt2;
      int c1_cnt;
      int c2_cnt;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             enable;
   logic [WIDTH-1:0] duty;
   logic [WIDTH-1:0] fs;
   logic [WIDTH-1:0] ph;
   logic [WIDTH-1:0] dt1;
   logic [WIDTH-1:0] dt2;
   logic [NPH-1:0]   c1;
   logic [NPH-1:0]   c2;
   logic             period_start;
   logic             running;

   int   n_pass = 0;
   int   n_total = 0;
   int   overlap_hits = 0;
   int   cur_p;
   int   off[NPH];
   int   exp_rise[NPH];
   int   cnt1[NPH];
   int   cnt2[NPH];
   int   rise1[NPH];
   int   pat_err[NPH];
   vec_t vecs[6];

   always #5 clk = ~clk;

   dpwm_multiphase #(
      .WIDTH (WIDTH),
      .NPH   (NPH)
   ) dut (
      .hf_clock     (clk),
      .reset        (rst_n),
      .enable       (enable),
      .duty_cycle   (duty),
      .fs           (fs),
      .phase_step   (ph),
      .deadtime1    (dt1),
      .deadtime2    (dt2),
      .c1           (c1),
      .c2           (c2),
      .period_start (period_start),
      .running      (running)
   );

   always @(negedge clk) begin
      if ((c1 & c2) != '0) overlap_hits++;
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ps(input string name);
      int n;
      n = 0;
      while (!period_start && n < 400) begin
         tick();
         n++;
      end
      check({name, " period_start seen"}, int'(period_start), 1);
   endtask

   task automatic wait_running(input string name, input int exp_edges);
      int n;
      n = 0;
      while (!running && n < 20) begin
         tick();
         n++;
      end
      check({name, " edges to running"}, n, exp_edges);
   endtask

   // Sample one full phase-0 period starting at a period_start cycle. Window
   // index j shows the outputs for phase-0 count j (one-cycle output latency).
   task automatic measure(input int e_duty, input int e_dt1, input int e_dt2,
                          input int chg_at, input int chg_duty);
      logic [NPH-1:0] prev;
      int             lcv;
      bit             e1;
      bit             e2;
      wait_ps("window");
      prev = c1;
      for (int k = 0; k < NPH; k++) begin
         cnt1[k] = 0; cnt2[k] = 0; rise1[k] = -1; pat_err[k] = 0;
      end
      for (int j = 0; j < cur_p; j++) begin
         if (j == chg_at) duty = WIDTH'(chg_duty);
         tick();
         for (int k = 0; k < NPH; k++) begin
            lcv = (j + off[k]) % cur_p;
            e1  = (lcv >= e_dt1) && (lcv < e_duty);
            e2  = (lcv >= e_duty + e_dt2) && (lcv < cur_p);
            if (c1[k] !== e1 || c2[k] !== e2) pat_err[k]++;
            if (c1[k]) cnt1[k]++;
            if (c2[k]) cnt2[k]++;
            if (c1[k] && !prev[k] && rise1[k] < 0) rise1[k] = j;
         end
         prev = c1;
      end
      check("period end pulse", int'(period_start), 1);
   endtask

   task automatic check_window(input string tag, input int c1e, input int c2e);
      for (int k = 0; k < NPH; k++) begin
         check($sformatf("%s ph%0d c1 count", tag, k), cnt1[k], c1e);
         check($sformatf("%s ph%0d c2 count", tag, k), cnt2[k], c2e);
         check($sformatf("%s ph%0d pattern errors", tag, k), pat_err[k], 0);
      end
   endtask

   initial begin
      vecs[0] = '{duty: 50,   dt1: 3,  dt2: 5,  c1_cnt: 47,  c2_cnt: 45};
      vecs[1] = '{duty: 0,    dt1: 0,  dt2: 0,  c1_cnt: 0,   c2_cnt: 100};
      vecs[2] = '{duty: 4095, dt1: 0,  dt2: 0,  c1_cnt: 100, c2_cnt: 0};
      vecs[3] = '{duty: 50,   dt1: 60, dt2: 0,  c1_cnt: 0,   c2_cnt: 50};
      vecs[4] = '{duty: 90,   dt1: 0,  dt2: 20, c1_cnt: 90,  c2_cnt: 0};
      vecs[5] = '{duty: 50,   dt1: 0,  dt2: 0,  c1_cnt: 50,  c2_cnt: 50};

      rst_n = 1'b0; enable = 1'b1;
      fs = 12'd99; ph = 12'd25; duty = 12'd50; dt1 = '0; dt2 = '0;
      cur_p = 100;
      off = '{0, 25, 50, 75};
      exp_rise = '{0, 75, 50, 25};
      repeat (3) tick();
      check("reset c1", int'(c1), 0);
      check("reset c2", int'(c2), 0);
      check("reset running", int'(running), 0);
      check("reset period_start", int'(period_start), 0);

      // Start-up: one edge into init, three offset cycles, then run.
      rst_n = 1'b1;
      wait_running("startup", 4);
      tick();
      check("first run c1", int'(c1), 4'b0011);
      begin
         int n;
         n = 1;
         while (!period_start && n < 300) begin
            tick();
            n++;
         end
         check("first period length", n, 100);
      end

      measure(50, 0, 0, -1, 0);
      check_window("base", 50, 50);
      for (int k = 0; k < NPH; k++) begin
         check($sformatf("base ph%0d c1 rise", k), rise1[k], exp_rise[k]);
      end

      foreach (vecs[v]) begin
         duty = WIDTH'(vecs[v].duty);
         dt1  = WIDTH'(vecs[v].dt1);
         dt2  = WIDTH'(vecs[v].dt2);
         measure(0, 0, 0, -1, 0);  // shadow still old in this window
         measure(vecs[v].duty, vecs[v].dt1, vecs[v].dt2, -1, 0);
         check_window($sformatf("vec%0d", v), vecs[v].c1_cnt, vecs[v].c2_cnt);
      end

      // Duty change at phase-0 count 40: current period unaffected.
      measure(50, 0, 0, 40, 80);
      check_window("pre-change", 50, 50);
      measure(80, 0, 0, -1, 0);
      check_window("post-change", 80, 20);

      // One-cycle reset mid-run with enable held high.
      repeat (10) tick();
      rst_n = 1'b0;
      tick();
      check("midreset c1", int'(c1), 0);
      check("midreset c2", int'(c2), 0);
      check("midreset running", int'(running), 0);
      rst_n = 1'b1;
      wait_running("restart", 4);
      tick();
      check("restart c1", int'(c1), 4'hF);
      begin
         int n;
         n = 1;
         while (!period_start && n < 300) begin
            tick();
            n++;
         end
         check("restart period length", n, 100);
      end

      // Uneven offsets: fs=10, step=7 -> 0, 7, 3, 10.
      enable = 1'b0;
      tick();
      check("disable running", int'(running), 0);
      check("disable c1", int'(c1), 0);
      fs = 12'd10; ph = 12'd7; duty = 12'd6; dt1 = 12'd1; dt2 = 12'd2;
      enable = 1'b1;
      cur_p = 11;
      off = '{0, 7, 3, 10};
      wait_running("fs10", 4);
      measure(6, 1, 2, -1, 0);
      check_window("fs10", 5, 3);
      fs = 12'd20;  // must be ignored until the next start
      measure(6, 1, 2, -1, 0);
      check_window("fs change ignored", 5, 3);

      check("c1/c2 overlap cycles", overlap_hits, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dpwm_multiphase.md
Name: dpwm_multiphase

Overview:
- N-phase interleaved digital PWM generator with per-phase complementary outputs and programmable dead-time.
- Successor to the single-phase DPWM: width and phase count are parameters; phases are evenly or arbitrarily shifted.
- Duty and dead-time updates are glitch-free, using shadow registers loaded only at the period boundary.
- Sits between the digital compensator (duty source) and the gate-driver pins, clocked by the high-frequency PWM clock.

Parameters:
- WIDTH, 12, bit width of counter, duty, period, dead-time and phase inputs.
- NPH, 4, number of phases (>=1); phase k output pair is c1[k]/c2[k].

Ports:
- hf_clock  in  1  PWM counter clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (reset=0 resets).
- enable  in  1  run request; 0 forces IDLE.
- duty_cycle  in  WIDTH  high-side on-count per period (shadowed).
- fs  in  WIDTH  period terminal count; period = fs+1 cycles (latched at start).
- phase_step  in  WIDTH  offset between adjacent phases in counts (latched at start).
- deadtime1  in  WIDTH  delay before high-side turn-on (shadowed).
- deadtime2  in  WIDTH  delay before low-side turn-on (shadowed).
- c1  out  NPH  high-side gate drives.
- c2  out  NPH  low-side gate drives.
- period_start  out  1  one-cycle pulse when phase-0 counter wraps to 0.
- running  out  1  high while in RUN.

Behaviour:
- Reset (reset=0 at a clock edge): state=IDLE; c1=0, c2=0, period_start=0, running=0; all counters, shadows and offsets are 0.
- FSM states: IDLE, INIT, RUN.
- IDLE -> INIT when enable=1.
  - Entering INIT latches fs_s=fs and ph_s=min(phase_step, fs).
  - It also loads duty_s, dt1_s and dt2_s from the inputs.
- INIT computes the phase offsets iteratively, one per cycle, for NPH-1 cycles (0 cycles if NPH=1):
  - off_0 = 0.
  - off_k = off_{k-1} + ph_s, minus (fs_s+1) if the sum is >= fs_s+1.
  - Arithmetic is WIDTH+1 bits.
  - The per-phase counter lc_k is loaded with off_k.
- INIT -> RUN after the last offset is computed; running=1 from the first RUN cycle.
- RUN, per cycle: each lc_k increments and wraps to 0 after reaching fs_s.
- RUN, at the phase-0 wrap (lc_0 == fs_s):
  - duty_s, dt1_s and dt2_s reload from the inputs; new values take effect from count 0 of the next period for all phases.
  - period_start pulses in the cycle where lc_0 becomes 0.
- Any state -> IDLE when enable=0; the next edge forces c1=c2=0 and running=0.
- fs and phase_step changes take effect only on the next IDLE->INIT.
- Output equations, registered (1-cycle latency from lc_k), compared in WIDTH+1 bits:
  - c1[k] = (lc_k >= dt1_s) && (lc_k < duty_s).
  - c2[k] = (lc_k >= duty_s + dt2_s) && (lc_k <= fs_s).
- Required invariant: c1[k] and c2[k] are never both 1, for any input combination.
- Boundary conditions:
  - duty_s=0: c1 stays 0; c2 is high from dt2_s to fs_s.
  - duty_s > fs_s: the c1 compare saturates (high from dt1_s through fs_s); c2 stays 0.
  - dt1_s >= duty_s: c1 stays 0 for the period.
  - duty_s+dt2_s > fs_s: c2 stays 0; no wrap of the sum.
  - fs=0: period is 1 cycle; all offsets are 0.
  - phase_step=0: all phases are identical.
- Reset mid-RUN: outputs go to 0 on the next edge and the FSM goes to IDLE, even when enable=1. The block re-enters INIT on the first edge after reset returns to 1.
- Input change in the same cycle as the phase-0 wrap: the new value is captured (shadow loads from the current inputs).

Decomposition:
- Shared package dpwm_pkg holds:
  - the FSM state encoding (IDLE/INIT/RUN);
  - a function wrap_add(a, b, mod) used by the offset computation;
  - the default WIDTH constant.
- Natural sub-module: dpwm_phase_cell, instantiated NPH times. It contains:
  - the per-phase counter lc_k with load/wrap;
  - the c1/c2 compare and output registers.
- The top level holds the FSM, the shadow registers and the offset accumulator.

Test Plan:
1. WIDTH=12, NPH=4, fs=99, phase_step=25, duty=50, dt1=dt2=0, enable from reset release.
   - Expected: period 100 cycles; phase k c1 rising edges are spaced 25 cycles apart (c1[k] rises 75 cycles after c1[k-1], i.e. lc_k leads by 25); each c1 is high 50 cycles.
2. Same setup with dt1=3, dt2=5.
   - Expected: c1 high for counts 3..49 (47 cycles); c2 high for counts 55..99 (45 cycles).
   - Expected: a continuous check over the whole run shows c1&c2 never both set.
3. Change duty 50->80 mid-period (lc_0=40).
   - Expected: the current period keeps c1 width 50; the next period after period_start shows width 80 on all phases.
4. Edge values: duty=0, then duty=4095 with fs=99, then dt1=60 with duty=50.
   - Expected in order: c1 always 0; c1 high through count 99 with c2=0; c1 always 0.
5. Assert reset=0 for 1 cycle mid-RUN with enable held at 1.
   - Expected: c1=c2=0 and running=0 the next cycle; INIT runs NPH-1=3 cycles; running=1 again; phase-0 restarts at count 0.
6. fs=10, phase_step=7, NPH=4.
   - Expected offsets: 0, 7, 3 (14-11), 10; the phase-wise lc pattern matches.
   - Expected: an fs change during RUN is ignored until an enable toggle.
